// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state encoding, reset defaults and mask helper for seq_detect_ctrl
package seq_detect_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  localparam int DEF_PATTERN = 5;
  localparam int DEF_LEN = 3;
  localparam logic DEF_OVERLAP = 1'b1;
  localparam int DEF_TARGET = 0;
  function automatic logic [63:0] len_mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: history shift register, fill counter and length-masked pattern compare
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int MAXLEN = 8,
  parameter int LENW = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              overlap_restart,
  input  logic              din,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LENW-1:0]   len,
  output logic              hit
);
  logic [MAXLEN-1:0] hist, hist_n, mask;
  logic [LENW-1:0] fill, fill_n;
  assign hist_n = {hist[MAXLEN-2:0], din};
  assign fill_n = (fill == LENW'(MAXLEN)) ? fill : fill + LENW'(1);
  assign mask = MAXLEN'(len_mask(int'(len)));
  assign hit = shift_en && (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);
  // a non-overlapping hit empties the fill so no matched bit is reused
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_n;
      fill <= (hit && overlap_restart) ? '0 : fill_n;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with arm/run/done lifecycle
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAXLEN = 8,
  parameter int CNTW = 8,
  parameter int LENW = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNTW-1:0]   cfg_target,
  output logic              cfg_err,
  input  logic              start,
  input  logic              abort,
  input  logic              din,
  input  logic              din_valid,
  output logic              match,
  output logic [CNTW-1:0]   match_count,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [MAXLEN-1:0] pattern;
  logic [LENW-1:0] len;
  logic overlap;
  logic [CNTW-1:0] target, count_n;
  logic cfg_ok, cfg_bad, go, shift_en, hit, fin;
  assign cfg_ok = cfg_we && (state != RUN);
  assign cfg_bad = (cfg_len == '0) || (cfg_len > LENW'(MAXLEN));
  assign go = start && !abort && (state != RUN);
  assign shift_en = (state == RUN) && din_valid && !abort;
  assign count_n = (match_count == '1) ? match_count : match_count + CNTW'(1);
  assign fin = hit && (target != '0) && (count_n == target);
  seq_match_core #(.MAXLEN(MAXLEN), .LENW(LENW)) u_core (
    .clk(clk),
    .reset(reset),
    .shift_en(shift_en),
    .clear(go),
    .overlap_restart(!overlap),
    .din(din),
    .pattern(pattern),
    .len(len),
    .hit(hit)
  );
  always_comb begin
    state_n = state;
    state_n = fin ? DONE : state_n;
    state_n = go ? RUN : state_n;
    state_n = abort ? IDLE : state_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pattern     <= MAXLEN'(DEF_PATTERN);
      len         <= LENW'(DEF_LEN);
      overlap     <= DEF_OVERLAP;
      target      <= CNTW'(DEF_TARGET);
      match_count <= '0;
      match       <= 1'b0;
      cfg_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state   <= state_n;
      match   <= hit;
      cfg_err <= cfg_ok && cfg_bad;
      busy    <= state_n == RUN;
      done    <= state_n == DONE;
      if (cfg_ok && !cfg_bad) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        target  <= cfg_target;
      end
      if (go) match_count <= '0;
      else if (hit) match_count <= count_n;
    end
  end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed scenario tests for seq_detect_ctrl
module tb_seq_detect_ctrl;
  logic clk = 0, reset = 0, cfg_we = 0, cfg_overlap = 0, start = 0, abort = 0, din = 0, din_valid = 0;
  logic [7:0] cfg_pattern = 0, cfg_target = 0;
  logic [3:0] cfg_len = 0;
  logic cfg_err, match, busy, done;
  logic [7:0] match_count;
  int checks = 0, failures = 0;

  seq_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start),
    .abort(abort), .din(din), .din_valid(din_valid), .match(match), .match_count(match_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] t);
    cfg_we = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
    tick();
    cfg_we = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic send(input logic b);
    din = b; din_valid = 1;
    tick();
    din_valid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    tick();
    @(negedge clk);
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    tick();
    if ({match, cfg_err, busy, done} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {match, cfg_err, busy, done});
    end
    checks++;
    if (match_count !== 8'd0) begin
      failures++; $display("FAIL reset_count got=%0d exp=0", match_count);
    end
    checks++;
    @(negedge clk);
    reset = 1;
    #1;
  endtask

  task automatic test_overlap();
    logic b[5] = '{1, 0, 1, 0, 1};
    logic e[5] = '{0, 0, 1, 0, 1};
    do_start();
    if (busy !== 1'b1) begin
      failures++; $display("FAIL s1_busy_after_start got=%b exp=1", busy);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      send(b[i]);
      if (match !== e[i]) begin
        failures++; $display("FAIL s1_match bit%0d got=%b exp=%b", i + 1, match, e[i]);
      end
      checks++;
    end
    if (match_count !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL s1_end got count=%0d busy=%b done=%b exp count=2 busy=1 done=0", match_count, busy, done);
    end
    checks++;
  endtask

  task automatic test_no_overlap();
    logic b[5] = '{1, 0, 1, 0, 1};
    logic e[5] = '{0, 0, 1, 0, 0};
    do_abort();
    cfg(8'd5, 4'd3, 1'b0, 8'd0);
    do_start();
    if (match_count !== 8'd0) begin
      failures++; $display("FAIL s2_count_cleared got=%0d exp=0", match_count);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      send(b[i]);
      if (match !== e[i]) begin
        failures++; $display("FAIL s2_match bit%0d got=%b exp=%b", i + 1, match, e[i]);
      end
      checks++;
    end
    if (match_count !== 8'd1) begin
      failures++; $display("FAIL s2_count got=%0d exp=1", match_count);
    end
    checks++;
  endtask

  task automatic test_target_done();
    logic b[7] = '{1, 1, 0, 1, 1, 0, 1};
    logic e[7] = '{0, 0, 0, 1, 0, 0, 1};
    logic x[4] = '{1, 1, 0, 1};
    do_abort();
    cfg(8'b1101, 4'd4, 1'b1, 8'd2);
    do_start();
    for (int i = 0; i < 7; i++) begin
      send(b[i]);
      if (match !== e[i]) begin
        failures++; $display("FAIL s3_match bit%0d got=%b exp=%b", i + 1, match, e[i]);
      end
      checks++;
    end
    if (done !== 1'b1 || busy !== 1'b0 || match_count !== 8'd2) begin
      failures++; $display("FAIL s3_done got done=%b busy=%b count=%0d exp done=1 busy=0 count=2", done, busy, match_count);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      send(x[i]);
      if (match !== 1'b0) begin
        failures++; $display("FAIL s3_done_ignored bit%0d got=%b exp=0", i + 1, match);
      end
      checks++;
    end
    if (match_count !== 8'd2 || done !== 1'b1) begin
      failures++; $display("FAIL s3_hold got count=%0d done=%b exp count=2 done=1", match_count, done);
    end
    checks++;
  endtask

  task automatic test_cfg_err();
    logic b[5] = '{1, 0, 1, 0, 1};
    logic e[5] = '{0, 0, 1, 0, 1};
    do_reset();
    cfg(8'b1101, 4'd0, 1'b0, 8'd1);
    if (cfg_err !== 1'b1) begin
      failures++; $display("FAIL s4_err_len0 got=%b exp=1", cfg_err);
    end
    checks++;
    tick();
    if (cfg_err !== 1'b0) begin
      failures++; $display("FAIL s4_err_pulse got=%b exp=0", cfg_err);
    end
    checks++;
    cfg(8'b1101, 4'd9, 1'b0, 8'd1);
    if (cfg_err !== 1'b1) begin
      failures++; $display("FAIL s4_err_len9 got=%b exp=1", cfg_err);
    end
    checks++;
    do_start();
    cfg(8'b1101, 4'd4, 1'b0, 8'd1);
    if (cfg_err !== 1'b0) begin
      failures++; $display("FAIL s4_err_in_run got=%b exp=0", cfg_err);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      send(b[i]);
      if (match !== e[i]) begin
        failures++; $display("FAIL s4_match bit%0d got=%b exp=%b", i + 1, match, e[i]);
      end
      checks++;
    end
    if (match_count !== 8'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL s4_count got count=%0d busy=%b exp count=2 busy=1", match_count, busy);
    end
    checks++;
  endtask

  task automatic test_valid_gap();
    logic g[3] = '{0, 1, 0};
    do_abort();
    do_start();
    send(1'b1);
    for (int i = 0; i < 3; i++) begin
      din = g[i]; din_valid = 0;
      tick();
      if (match !== 1'b0) begin
        failures++; $display("FAIL s5_invalid cyc%0d got=%b exp=0", i, match);
      end
      checks++;
    end
    send(1'b0);
    if (match !== 1'b0) begin
      failures++; $display("FAIL s5_bit2 got=%b exp=0", match);
    end
    checks++;
    send(1'b1);
    if (match !== 1'b1 || match_count !== 8'd1) begin
      failures++; $display("FAIL s5_final got match=%b count=%0d exp match=1 count=1", match, match_count);
    end
    checks++;
  endtask

  task automatic test_abort_reset();
    logic b[6] = '{1, 1, 0, 1, 1, 0};
    do_abort();
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL s6_abort_wins got busy=%b done=%b exp busy=0 done=0", busy, done);
    end
    checks++;
    cfg(8'b110, 4'd3, 1'b1, 8'd0);
    do_start();
    for (int i = 0; i < 6; i++) send(b[i]);
    if (match !== 1'b1 || match_count !== 8'd2 || busy !== 1'b1) begin
      failures++; $display("FAIL s6_pre_reset got match=%b count=%0d busy=%b exp 1 2 1", match, match_count, busy);
    end
    checks++;
    #2 reset = 0;
    #1;
    if ({match, busy, done, cfg_err} !== 4'b0000 || match_count !== 8'd0) begin
      failures++; $display("FAIL s6_async_reset got flags=%b count=%0d exp flags=0000 count=0", {match, busy, done, cfg_err}, match_count);
    end
    checks++;
    @(negedge clk);
    reset = 1;
    #1;
    do_start();
    send(1'b1); send(1'b0); send(1'b1);
    if (match !== 1'b1 || match_count !== 8'd1) begin
      failures++; $display("FAIL s6_defaults got match=%b count=%0d exp match=1 count=1", match, match_count);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_target_done();
    test_cfg_err();
    test_valid_gap();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. It accepts a configurable bit pattern (1..MAXLEN bits), overlap mode and match target. It scans a qualified serial input stream and sequences an arm/run/done lifecycle, counting matches and signalling completion. It sits between a host/config master and the serial din stream, and replaces fixed-pattern detectors. Its reset defaults reproduce "101", overlapping.

Parameters:
MAXLEN, 8, maximum pattern length in bits (>=2)
CNTW, 8, width of match counter and target
LENW, $clog2(MAXLEN+1), width of length fields (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  config write strobe
cfg_pattern  in  MAXLEN  pattern; first-received bit at index cfg_len-1, last at index 0
cfg_len  in  LENW  pattern length, legal 1..MAXLEN
cfg_overlap  in  1  1 = overlapping matches, 0 = restart after a match
cfg_target  in  CNTW  matches required to finish; 0 = run until abort
cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected
start  in  1  arm and run
abort  in  1  return to IDLE
din  in  1  serial data bit
din_valid  in  1  din qualifier
match  out  1  one-cycle pulse per detected match
match_count  out  CNTW  matches since last start, saturating
busy  out  1  high in RUN
done  out  1  high in DONE (level)

Behaviour:
- Reset, asynchronous, effective immediately, including mid-RUN:
  - state IDLE; hist=0; fill=0; match_count=0
  - match, cfg_err, busy, done all 0
  - pattern=...0101 (value 5), len=3, overlap=1, target=0
- States: IDLE, RUN, DONE. Encoding lives in the package.
- Config: cfg_we is accepted only in IDLE or DONE and takes effect the next cycle.
  - cfg_len==0 or cfg_len>MAXLEN: no register changes; cfg_err=1 for 1 cycle.
  - cfg_we in RUN: ignored silently, no cfg_err.
- start in IDLE/DONE -> RUN next cycle. This clears hist, fill, match_count and done. start in RUN is ignored.
- abort in any state -> IDLE next cycle. match_count is retained.
- abort and start in the same cycle: abort wins.
- RUN, on each cycle with din_valid=1:
  - hist_n = {hist[MAXLEN-2:0], din}; fill_n = min(fill+1, MAXLEN)
  - hit = (fill_n >= len) && (hist_n[len-1:0] == pattern[len-1:0])
  - On hit: match=1 on the following cycle (1-cycle registered latency from the completing bit); match_count increments, saturating at 2^CNTW-1.
  - On hit with overlap=0: fill <= 0, so no bit of a matched pattern is reused. hist still shifts.
- din_valid=0, or state != RUN: no shift, no fill change, no match.
- Completion: if target!=0 and the incremented count == target, state -> DONE in the same edge. match and done are both high on that first DONE cycle; busy drops on that cycle. Bits arriving in DONE are ignored.
- target!=0 with target <= count at start is impossible, because start clears the count.
- busy = (state==RUN); done = (state==DONE).
- All outputs are registered.

Decomposition:
- Package seq_detect_pkg holds:
  - state enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - reset-default constants: DEF_PATTERN=5, DEF_LEN=3, DEF_OVERLAP=1, DEF_TARGET=0
  - a length-mask function
- Sub-module seq_match_core (params MAXLEN, LENW):
  - contains the history shift register, fill counter and masked compare
  - inputs: shift_en, clear, overlap_restart, din, pattern, len
  - output: hit (combinational, from next-state values)
- Top level holds the FSM, config registers, counter and output registers.

Test Plan:
1. Reset defaults, start, din stream 1,0,1,0,1 (valid every cycle) -> match pulses the cycle after bit 3 and after bit 5; match_count=2; busy=1; done=0.
2. Same as scenario 1 with cfg_overlap=0 written first -> single match after bit 3; match_count=1.
3. cfg pattern=4'b1101, len=4, target=2, overlap=1; start; stream 1,1,0,1,1,0,1 -> matches after bits 4 and 7. On the cycle after bit 7: match=1, done=1, busy=0, count=2. A further 1,1,0,1 produces no match and the count stays 2.
4. cfg_len=0 write in IDLE -> cfg_err 1-cycle pulse, defaults kept. cfg_we with len=4 during RUN -> ignored, cfg_err=0, "101" still detected.
5. Stream 1,(valid=0 x3),0,1 with din toggling while invalid -> exactly one match, after the final valid 1.
6. start+abort in the same cycle -> IDLE. Mid-RUN reset low with count=2 -> outputs zero asynchronously before the next clk edge; defaults restored.
